// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword/word load-store engine in front of a word-wide, big-endian data memory.
// Latency accept->resp_valid: error 1, load 2, store word 2, store byte/halfword 3 (read-modify-write).
// Backpressure: one request in flight, req_ready only in IDLE. Optional macro MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_signed,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_dir,
  output logic [31:0] mem_writedato,
  output logic        mem_writeEN,
  output logic        mem_MemRead,
  input  logic [31:0] mem_dato
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        r_write;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [31:0] r_waddr;

  logic [31:0] req_waddr;
  logic [32:0] req_last;
  logic        req_err;
  logic        need_read;

  // Classify the incoming request: bounds are checked on the raw address so an
  // access reaching past the end of memory is rejected before alignment is forced.
  always_comb begin
    req_waddr = {req_addr[31:2], 2'b00};
    req_last  = {1'b0, req_addr} + 33'd3;
    req_err   = (req_size == 2'b11) || (req_last >= 33'(MEM_BYTES));
`ifdef MISALIGN_TRAP_EN
    if ((req_size == SZ_H && req_addr[0]) || (req_size == SZ_W && req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
    need_read = !req_write || (req_size != SZ_W);
  end

  // Pick the addressed lane out of a big-endian word and extend it.
  // Halfwords only look at lane[1], which is what forces their alignment.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = lane[1] ? w[15:0] : w[31:16];
    case (size)
      SZ_B:    r = {{24{sx & b[7]}}, b};
      SZ_H:    r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/halfword lane of the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (size == SZ_H) begin
      if (lane[1]) r[15:0]  = d;
      else         r[31:16] = d;
    end else begin
      case (lane)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end
    return r;
  endfunction

  // Access sequencer: outputs are registered and loaded on the edge entering each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
      mem_dir       <= '0;
      mem_writedato <= '0;
      mem_writeEN   <= 1'b0;
      mem_MemRead   <= 1'b0;
      r_write       <= 1'b0;
      r_signed      <= 1'b0;
      r_size        <= '0;
      r_lane        <= '0;
      r_wdata       <= '0;
      r_waddr       <= '0;
    end else begin
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
      mem_dir       <= '0;
      mem_writedato <= '0;
      mem_writeEN   <= 1'b0;
      mem_MemRead   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            r_write   <= req_write;
            r_signed  <= req_signed;
            r_size    <= req_size;
            r_lane    <= req_addr[1:0];
            r_wdata   <= req_wdata[15:0];
            r_waddr   <= req_waddr;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (need_read) begin
              state       <= RD;
              mem_dir     <= req_waddr;
              mem_MemRead <= 1'b1;
            end else begin
              state         <= WR;
              mem_dir       <= req_waddr;
              mem_writeEN   <= 1'b1;
              mem_writedato <= req_wdata;
            end
          end
        end
        RD: begin
          if (r_write) begin
            state         <= WR;
            mem_dir       <= r_waddr;
            mem_writeEN   <= 1'b1;
            mem_writedato <= store_merge(mem_dato, r_lane, r_size, r_wdata);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_extract(mem_dato, r_lane, r_size, r_signed);
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scenarios plus random loads/stores against a byte-array reference model.
module tb_mem_access_unit;
  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_dir;
  logic [31:0] mem_writedato;
  logic        mem_writeEN;
  logic        mem_MemRead;
  logic [31:0] mem_dato;

  mem_access_unit #(.MEM_BYTES(MB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_signed(req_signed), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_dir(mem_dir), .mem_writedato(mem_writedato), .mem_writeEN(mem_writeEN),
    .mem_MemRead(mem_MemRead), .mem_dato(mem_dato)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT (byte array, big-endian words) and the reference copy.
  logic [7:0] dmem [MB];
  logic [7:0] rmem [MB];

  assign mem_dato = {dmem[{mem_dir[9:2], 2'b00}], dmem[{mem_dir[9:2], 2'b01}],
                     dmem[{mem_dir[9:2], 2'b10}], dmem[{mem_dir[9:2], 2'b11}]};

  always @(posedge clk) begin
    if (mem_writeEN) begin
      dmem[{mem_dir[9:2], 2'b00}] = mem_writedato[31:24];
      dmem[{mem_dir[9:2], 2'b01}] = mem_writedato[23:16];
      dmem[{mem_dir[9:2], 2'b10}] = mem_writedato[15:8];
      dmem[{mem_dir[9:2], 2'b11}] = mem_writedato[7:0];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Activity monitor, sampled mid-cycle.
  int wr_cnt = 0, rd_cnt = 0, resp_cnt = 0, err_cnt = 0;
  int bad_rdy = 0, idle_bad = 0, dir_bad = 0;
  logic [31:0] last_wdat = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_writeEN) begin wr_cnt++; last_wdat = mem_writedato; end
      if (mem_MemRead) rd_cnt++;
      if (resp_valid) resp_cnt++;
      if (resp_valid && resp_err) err_cnt++;
      if (resp_valid && req_ready) bad_rdy++;
      if (!resp_valid && (resp_rdata != 0 || resp_err)) idle_bad++;
      if (!mem_writeEN && !mem_MemRead && mem_dir != 0) dir_bad++;
      if (mem_writeEN && mem_MemRead) dir_bad++;
    end
  end

  function automatic logic [31:0] ref_word(input int a);
    return {rmem[a], rmem[a+1], rmem[a+2], rmem[a+3]};
  endfunction

  task automatic poke(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      dmem[a+i] = w[8*(3-i) +: 8];
      rmem[a+i] = w[8*(3-i) +: 8];
    end
  endtask

  // Reference behaviour straight from the access rules; updates rmem for stores.
  task automatic model(input logic w, input logic s, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd,
                       output int lat, output int ea);
    int n;
    logic [63:0] v;
    e = (sz == 2'b11) || (({32'b0, a} + 64'd3) >= 64'(MB));
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'b01 && a[0]) e = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) e = 1'b1;
`endif
    rd = '0;
    ea = 0;
    lat = 1;
    if (e) return;
    n = 1 << sz;
    ea = int'(a) & ~(n - 1);
    if (!w) begin
      v = '0;
      for (int i = 0; i < n; i++) v = (v << 8) | 64'(rmem[ea+i]);
      if (s && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      rd = v[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < n; i++) rmem[ea+i] = wd[8*(n-1-i) +: 8];
      lat = (n == 4) ? 2 : 3;
    end
  endtask

  task automatic xact(input string tag, input logic w, input logic s, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic        ee;
    logic [31:0] er;
    int          el, ea, lat;
    model(w, s, sz, a, wd, ee, er, el, ea);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_signed = s; req_size = sz;
    req_addr = a; req_wdata = wd;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    wr_cnt = 0; rd_cnt = 0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 9;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) begin lat = c; break; end
    end
    got = resp_rdata;
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " err"}, 32'(resp_err), 32'(ee));
    chk({tag, " rdata"}, resp_rdata, er);
    chk({tag, " writes"}, 32'(wr_cnt), (w && !ee) ? 32'd1 : 32'd0);
    chk({tag, " reads"}, 32'(rd_cnt), (!ee && !(w && sz == 2'b10)) ? 32'd1 : 32'd0);
    if (w && !ee) chk({tag, " wdat"}, last_wdat, ref_word(ea & ~3));
  endtask

  initial begin
    logic [31:0] got, er;
    logic        ee;
    int          el, ea, r0, e0;

    for (int i = 0; i < MB; i++) begin
      dmem[i] = 8'($urandom);
      rmem[i] = dmem[i];
    end

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst mem_dir", mem_dir, 32'd0);
    chk("rst writedato", mem_writedato, 32'd0);
    chk("rst writeEN", 32'(mem_writeEN), 32'd0);
    chk("rst MemRead", 32'(mem_MemRead), 32'd0);
    reset = 1'b0;

    // Store word then signed byte load of its last byte
    xact("sw10", 1'b1, 1'b0, 2'b10, 32'h10, 32'h11223344, got);
    chk("sw10 data", last_wdat, 32'h11223344);
    xact("lb13", 1'b0, 1'b1, 2'b00, 32'h13, 32'h0, got);
    chk("lb13 value", got, 32'h00000044);

    // Byte store read-modify-write
    poke(32'h20, 32'hAABBCCDD);
    xact("sb21", 1'b1, 1'b0, 2'b00, 32'h21, 32'h0000005A, got);
    chk("sb21 merged", last_wdat, 32'hAA5ACCDD);

    // Halfword loads, signed and unsigned
    poke(32'h20, 32'h8001FFFF);
    xact("lhs20", 1'b0, 1'b1, 2'b01, 32'h20, 32'h0, got);
    chk("lhs20 value", got, 32'hFFFF8001);
    xact("lhu20", 1'b0, 1'b0, 2'b01, 32'h20, 32'h0, got);
    chk("lhu20 value", got, 32'h00008001);

    // Out of range store, misaligned word load
    xact("sw3fe", 1'b1, 1'b0, 2'b10, 32'h3FE, 32'hDEADBEEF, got);
    poke(32'h20, 32'hCAFEF00D);
    xact("lw22", 1'b0, 1'b0, 2'b10, 32'h22, 32'h0, got);
`ifdef MISALIGN_TRAP_EN
    chk("lw22 value", got, 32'h0);
`else
    chk("lw22 value", got, 32'hCAFEF00D);
`endif

    // Reset while the write cycle of a byte store is on the memory bus
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_signed = 1'b0; req_size = 2'b00;
    req_addr = 32'h41; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort in WR", 32'(mem_writeEN), 32'd1);
    r0 = resp_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("abort ready", 32'(req_ready), 32'd1);
    chk("abort resp_valid", 32'(resp_valid), 32'd0);
    chk("abort writeEN", 32'(mem_writeEN), 32'd0);
    reset = 1'b0;
    model(1'b1, 1'b0, 2'b00, 32'h41, 32'h77, ee, er, el, ea);
    repeat (3) @(negedge clk);
    chk("abort no resp", 32'(resp_cnt - r0), 32'd0);

    // Illegal size held valid across four edges -> two accepts, two error pulses
    @(negedge clk);
    r0 = resp_cnt; e0 = err_cnt; wr_cnt = 0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_addr = 32'h8;
    repeat (4) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sz11 resp pulses", 32'(resp_cnt - r0), 32'd2);
    chk("sz11 err pulses", 32'(err_cnt - e0), 32'd2);
    chk("sz11 writes", 32'(wr_cnt), 32'd0);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      xact("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
           32'($urandom_range(0, MB + 40)), $urandom, got);
    end

    // Global invariants and final memory image
    chk("ready during resp", 32'(bad_rdy), 32'd0);
    chk("resp fields idle", 32'(idle_bad), 32'd0);
    chk("mem bus idle", 32'(dir_bad), 32'd0);
    r0 = 0;
    for (int i = 0; i < MB; i++) if (dmem[i] !== rmem[i]) r0++;
    chk("memory image", 32'(r0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
